// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Parameterised multi-read / single-write register file with a
//               self-sequenced zeroing phase after reset or clr, optional
//               write-to-read forwarding and optional hardwired-zero x0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   addrR,
    output logic [NRD*XLEN-1:0] dataR,
    input  logic [AW-1:0]       addrD,
    input  logic [XLEN-1:0]     dataD,
    input  logic                wEn,
    input  logic                clr,
    output logic                ready,
    output logic                wErr
);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   clrIdx_q, clrIdx_d;
    logic            wErr_q, wErr_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic w_wrIgnored;
    logic w_wrCommit;

    // A write lands only in RUN, not on a clr edge, and never on a hardwired x0
    assign w_wrIgnored = (ZERO_R0 != 0) && (addrD == '0);
    assign w_wrCommit  = (state_q == S_RUN) && wEn && !clr && !w_wrIgnored;

    assign ready = (state_q == S_RUN);
    assign wErr  = wErr_q;

    // Next-state logic: walk clrIdx through every register, then run until clr
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        wErr_d   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                // Writes arriving while zeroing are dropped and flagged
                wErr_d = wEn;
                if (clrIdx_q == LAST_IDX) begin
                    state_d = S_RUN;
                end else begin
                    clrIdx_d = clrIdx_q + 1'b1;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_d  = S_CLEAR;
                    clrIdx_d = '0;
                end
            end
            default: begin
                state_d  = S_CLEAR;
                clrIdx_d = '0;
            end
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            clrIdx_q <= '0;
            wErr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
            wErr_q   <= wErr_d;
        end
    end

    // Storage update: zero one entry per cycle while clearing, else accept writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                regs_q[clrIdx_q] <= '0;
            end else if (w_wrCommit) begin
                regs_q[addrD] <= dataD;
            end
        end
    end

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_rdata;

            assign w_addr = addrR[k*AW +: AW];

            // Read mux: gated to zero until ready, x0 masking, optional forwarding
            always_comb begin
                w_rdata = regs_q[w_addr];
                if (!ready) begin
                    w_rdata = '0;
                end else if ((ZERO_R0 != 0) && (w_addr == '0)) begin
                    w_rdata = '0;
                end else if ((BYPASS != 0) && w_wrCommit && (addrD == w_addr)) begin
                    w_rdata = dataD;
                end
            end

            assign dataR[k*XLEN +: XLEN] = w_rdata;
        end
    endgenerate

endmodule
`default_nettype wire
